// File: rtl/a_regfile_wb.sv
// a_regfile_wb: the eight A (address) registers with result-bus write-back,
// a maintenance write port, three combinational read ports and registered
// A0 status flags. Data moves bit-exact; there is no arithmetic here.
module a_regfile_wb #(
  parameter int AWIDTH = 24,
  parameter int NSRC   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_result_en,
  input  logic [3:0]             i_result_src,
  input  logic [2:0]             i_result_dest,
  input  logic [NSRC*AWIDTH-1:0] i_src_data,
  input  logic [2:0]             i_rd_i,
  input  logic [2:0]             i_rd_j,
  input  logic [2:0]             i_rd_k,
  output logic [AWIDTH-1:0]      o_ai,
  output logic [AWIDTH-1:0]      o_aj,
  output logic [AWIDTH-1:0]      o_ak,
  output logic [AWIDTH-1:0]      o_a0,
  input  logic                   i_mnt_we,
  input  logic [2:0]             i_mnt_addr,
  input  logic [AWIDTH-1:0]      i_mnt_data,
  output logic                   o_a0_zero,
  output logic                   o_a0_neg,
  output logic                   o_src_err,
  output logic                   o_mnt_conflict
);

  localparam int NREG = 8;

  logic [NREG-1:0][AWIDTH-1:0] a_q;

  logic              src_hit;
  logic [AWIDTH-1:0] src_sel;
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [AWIDTH-1:0] wr_data;
  logic [AWIDTH-1:0] a0_nxt;

  // Source mux: an unmatched (illegal) code leaves src_sel at zero, which is
  // exactly the value an illegal-source write must deposit.
  always_comb begin
    src_hit = 1'b0;
    src_sel = '0;
    for (int n = 0; n < NSRC; n++) begin
      if (i_result_src == 4'(n)) begin
        src_hit = 1'b1;
        src_sel = i_src_data[n*AWIDTH +: AWIDTH];
      end
    end
  end

  // Single write port: the result bus always beats the maintenance port.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (i_result_en) begin
      wr_en   = 1'b1;
      wr_addr = i_result_dest;
      wr_data = src_sel;
    end else if (i_mnt_we) begin
      wr_en   = 1'b1;
      wr_addr = i_mnt_addr;
      wr_data = i_mnt_data;
    end
  end

  // Next-state A0 feeds the flag registers so flags never lag o_a0.
  always_comb begin
    a0_nxt = a_q[0];
    if (wr_en && wr_addr == 3'd0) a0_nxt = wr_data;
  end

  // Register array update, at most one entry per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (wr_en && wr_addr == 3'(r)) a_q[r] <= wr_data;
      end
    end
  end

  // A0 status flags and one-cycle error/conflict pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_a0_zero      <= 1'b1;
      o_a0_neg       <= 1'b0;
      o_src_err      <= 1'b0;
      o_mnt_conflict <= 1'b0;
    end else begin
      o_a0_zero      <= (a0_nxt == '0);
      o_a0_neg       <= a0_nxt[AWIDTH-1];
      o_src_err      <= i_result_en && !src_hit;
      o_mnt_conflict <= i_result_en && i_mnt_we;
    end
  end

  // Read ports: plain muxes of current contents, no write bypass.
  assign o_ai = a_q[i_rd_i];
  assign o_aj = a_q[i_rd_j];
  assign o_ak = a_q[i_rd_k];
  assign o_a0 = a_q[0];

endmodule

// File: tb/tb_a_regfile_wb.sv
// tb_a_regfile_wb: directed cases plus randomized traffic against an
// array-based reference model of the A register file.
module tb_a_regfile_wb;

  localparam int AW   = 24;
  localparam int NSRC = 8;

  logic                 clk;
  logic                 rst;
  logic                 i_result_en;
  logic [3:0]           i_result_src;
  logic [2:0]           i_result_dest;
  logic [NSRC*AW-1:0]   i_src_data;
  logic [2:0]           i_rd_i, i_rd_j, i_rd_k;
  logic [AW-1:0]        o_ai, o_aj, o_ak, o_a0;
  logic                 i_mnt_we;
  logic [2:0]           i_mnt_addr;
  logic [AW-1:0]        i_mnt_data;
  logic                 o_a0_zero, o_a0_neg, o_src_err, o_mnt_conflict;

  a_regfile_wb #(.AWIDTH(AW), .NSRC(NSRC)) dut (
    .clk(clk), .rst(rst),
    .i_result_en(i_result_en), .i_result_src(i_result_src),
    .i_result_dest(i_result_dest), .i_src_data(i_src_data),
    .i_rd_i(i_rd_i), .i_rd_j(i_rd_j), .i_rd_k(i_rd_k),
    .o_ai(o_ai), .o_aj(o_aj), .o_ak(o_ak), .o_a0(o_a0),
    .i_mnt_we(i_mnt_we), .i_mnt_addr(i_mnt_addr), .i_mnt_data(i_mnt_data),
    .o_a0_zero(o_a0_zero), .o_a0_neg(o_a0_neg),
    .o_src_err(o_src_err), .o_mnt_conflict(o_mnt_conflict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference state
  logic [AW-1:0] ref_a [8];
  logic          ref_src_err, ref_conflict;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic ref_reset();
    for (int r = 0; r < 8; r++) ref_a[r] = '0;
    ref_src_err  = 1'b0;
    ref_conflict = 1'b0;
  endtask

  // Apply the write rules for the inputs present at this edge.
  task automatic ref_edge();
    int s;
    s = int'(i_result_src);
    ref_src_err  = i_result_en && (s >= NSRC);
    ref_conflict = i_result_en && i_mnt_we;
    if (i_result_en)
      ref_a[i_result_dest] = (s < NSRC) ? i_src_data[s*AW +: AW] : '0;
    else if (i_mnt_we)
      ref_a[i_mnt_addr] = i_mnt_data;
  endtask

  task automatic chk_reads(input string tag);
    chk({tag, "_ai"}, 32'(o_ai), 32'(ref_a[i_rd_i]));
    chk({tag, "_aj"}, 32'(o_aj), 32'(ref_a[i_rd_j]));
    chk({tag, "_ak"}, 32'(o_ak), 32'(ref_a[i_rd_k]));
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_a0"},   32'(o_a0), 32'(ref_a[0]));
    chk({tag, "_zero"}, 32'(o_a0_zero), 32'(ref_a[0] == '0));
    chk({tag, "_neg"},  32'(o_a0_neg),  32'(ref_a[0][AW-1]));
    chk({tag, "_serr"}, 32'(o_src_err), 32'(ref_src_err));
    chk({tag, "_conf"}, 32'(o_mnt_conflict), 32'(ref_conflict));
  endtask

  // Called at posedge+1 with inputs freshly driven: check pre-edge reads
  // (old values, no bypass), clock, then check post-edge state and reads.
  task automatic cycle(input string tag);
    #1 chk_reads({tag, "_pre"});
    @(posedge clk);
    ref_edge();
    #1;
    chk_state(tag);
    chk_reads({tag, "_post"});
  endtask

  task automatic idle();
    i_result_en = 1'b0; i_result_src = '0; i_result_dest = '0;
    i_mnt_we = 1'b0; i_mnt_addr = '0; i_mnt_data = '0;
  endtask

  task automatic res_wr(input logic [3:0] src, input logic [2:0] dest, input logic [AW-1:0] val);
    i_result_en = 1'b1; i_result_src = src; i_result_dest = dest;
    if (int'(src) < NSRC) i_src_data[int'(src)*AW +: AW] = val;
  endtask

  task automatic mnt_wr(input logic [2:0] addr, input logic [AW-1:0] val);
    i_mnt_we = 1'b1; i_mnt_addr = addr; i_mnt_data = val;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    i_src_data = '0;
    i_rd_i = '0; i_rd_j = '0; i_rd_k = '0;
    ref_reset();

    // Reset state while held
    #12;
    chk_state("rst_hold");
    chk_reads("rst_hold");
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;

    // Basic write-back, back-to-back to dest 5 then 6
    i_rd_j = 3'd5; i_rd_k = 3'd6;
    res_wr(4'd2, 3'd5, 24'h123456);
    cycle("wb5");
    chk("wb5_aj", 32'(o_aj), 32'h123456);
    res_wr(4'd3, 3'd6, 24'h654321);
    cycle("wb6");
    chk("wb6_aj", 32'(o_aj), 32'h123456);
    chk("wb6_ak", 32'(o_ak), 32'h654321);

    // A0 flags
    idle(); res_wr(4'd0, 3'd0, 24'h800000);
    cycle("a0neg");
    chk("a0neg_neg", 32'(o_a0_neg), 32'd1);
    chk("a0neg_zero", 32'(o_a0_zero), 32'd0);
    res_wr(4'd1, 3'd0, 24'h000000);
    cycle("a0zero");
    chk("a0zero_zero", 32'(o_a0_zero), 32'd1);
    chk("a0zero_neg", 32'(o_a0_neg), 32'd0);

    // Illegal source
    idle(); mnt_wr(3'd2, 24'h00FFFF);
    i_rd_i = 3'd2;
    cycle("ill_pre");
    idle(); res_wr(4'd11, 3'd2, '0);
    cycle("ill");
    chk("ill_a2", 32'(o_ai), 32'd0);
    chk("ill_serr", 32'(o_src_err), 32'd1);
    idle(); i_result_src = 4'd11; i_result_dest = 3'd2;
    cycle("ill_off");
    chk("ill_off_serr", 32'(o_src_err), 32'd0);

    // Maintenance conflict then lone maintenance write
    idle(); i_rd_i = 3'd1; i_rd_j = 3'd4;
    mnt_wr(3'd1, 24'h0000AA); res_wr(4'd5, 3'd4, 24'h0BEEF0);
    cycle("conf");
    chk("conf_a4", 32'(o_aj), 32'h0BEEF0);
    chk("conf_a1", 32'(o_ai), 32'd0);
    chk("conf_pulse", 32'(o_mnt_conflict), 32'd1);
    idle(); mnt_wr(3'd1, 24'h0000AA);
    cycle("mnt");
    chk("mnt_a1", 32'(o_ai), 32'h0000AA);
    chk("mnt_pulse", 32'(o_mnt_conflict), 32'd0);

    // Read-port sweep with A[n] = 0x10 + n
    for (int n = 0; n < 8; n++) begin
      idle(); mnt_wr(3'(n), AW'(24'h10 + n));
      cycle("ld");
    end
    idle();
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 8; c++) begin
          i_rd_i = 3'(a); i_rd_j = 3'(b); i_rd_k = 3'(c);
          #1;
          chk("sw_ai", 32'(o_ai), 32'(24'h10 + a));
          chk("sw_aj", 32'(o_aj), 32'(24'h10 + b));
          chk("sw_ak", 32'(o_ak), 32'(24'h10 + c));
        end
    @(posedge clk) #1;

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      idle();
      for (int n = 0; n < NSRC; n++)
        i_src_data[n*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'(0) :
                                 ($urandom_range(0, 3) == 0) ? AW'(24'h800000) : AW'($urandom);
      i_result_en   = ($urandom_range(0, 2) != 0);
      i_result_src  = 4'($urandom_range(0, 10));
      i_result_dest = 3'($urandom);
      i_mnt_we      = ($urandom_range(0, 2) == 0);
      i_mnt_addr    = 3'($urandom);
      i_mnt_data    = ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom);
      i_rd_i = 3'($urandom); i_rd_j = 3'($urandom); i_rd_k = 3'($urandom);
      cycle("rnd");
    end

    // Asynchronous reset mid-cycle with a pending write
    idle(); mnt_wr(3'd3, 24'h00ABCD); i_rd_i = 3'd3;
    cycle("r3");
    chk("r3_val", 32'(o_ai), 32'h00ABCD);
    idle(); res_wr(4'd1, 3'd0, 24'h000055); mnt_wr(3'd1, 24'h000077);
    #2 rst = 1'b0;
    ref_reset();
    #1;
    chk_state("arst");
    chk("arst_a3", 32'(o_ai), 32'd0);
    @(posedge clk) #1;
    chk_state("arst_edge");
    idle();
    @(negedge clk) rst = 1'b1;
    cycle("arst_rel");
    chk("arst_rel_a3", 32'(o_ai), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/a_regfile_wb.md
Name: a_regfile_wb

Overview:
- Holds the eight A (address) registers and performs A result-bus write-back.
- Consumes the A scheduler's per-cycle result-bus triple (enable, source code, destination) and steers the selected functional-unit output into the addressed register.
- Supplies three combinational read ports (i, j, k fields) to the address functional units.
- Supplies registered A0 status flags (zero, negative) to the branch logic.
- Provides a maintenance write port for deadstart/register initialisation.

Parameters:
AWIDTH, 24, width of each A register and of every source bus.
NSRC, 8, number of result-bus sources packed on i_src_data (legal source codes 0..NSRC-1, NSRC <= 16).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
i_result_en  input  1  result-bus write enable for this cycle (from the A scheduler)
i_result_src  input  4  source code selecting a slice of i_src_data
i_result_dest  input  3  destination A register index
i_src_data  input  NSRC*AWIDTH  packed source buses; source n occupies bits [n*AWIDTH +: AWIDTH]
i_rd_i  input  3  read address, port i
i_rd_j  input  3  read address, port j
i_rd_k  input  3  read address, port k
o_ai  output  AWIDTH  contents of A[i_rd_i], combinational
o_aj  output  AWIDTH  contents of A[i_rd_j], combinational
o_ak  output  AWIDTH  contents of A[i_rd_k], combinational
o_a0  output  AWIDTH  contents of A0, combinational from the register
i_mnt_we  input  1  maintenance write enable
i_mnt_addr  input  3  maintenance write register index
i_mnt_data  input  AWIDTH  maintenance write data
o_a0_zero  output  1  registered: A0 == 0
o_a0_neg  output  1  registered: A0[AWIDTH-1]
o_src_err  output  1  registered one-cycle pulse: illegal source code written
o_mnt_conflict  output  1  registered one-cycle pulse: maintenance write dropped

Behaviour:
Reset (asynchronous assertion when rst goes low; synchronous deassertion release):
- A0..A7 = 0; o_a0_zero = 1; o_a0_neg = 0; o_src_err = 0; o_mnt_conflict = 0.
- Reset asserted mid-operation aborts any pending write in that cycle.

Result write:
- On a rising edge with i_result_en = 1: A[i_result_dest] <= slice i_result_src of i_src_data.
- Exactly one register is written per cycle.
- Write latency is one cycle. The value is visible on the read ports and o_a0 in the cycle after the enable cycle. This matches the scheduler clearing its reservation bit in that same cycle.
- No read-during-write bypass: a read of the destination in the enable cycle returns the old value. The scheduler reservation mask guarantees this is never consumed.
- Illegal source (i_result_src >= NSRC) with i_result_en = 1:
  - The destination is written with 0.
  - o_src_err = 1 in the next cycle only.
- i_result_en = 0: i_result_src, i_result_dest and i_src_data are ignored; no state change.

Maintenance write:
- On an edge with i_mnt_we = 1 and i_result_en = 0: A[i_mnt_addr] <= i_mnt_data.
- If i_mnt_we and i_result_en are both 1: the result bus wins, the maintenance write is dropped (even if the addresses differ), and o_mnt_conflict = 1 in the next cycle.

A0 flags:
- o_a0_zero and o_a0_neg are computed from the next-state A0 and registered. They are therefore always consistent with o_a0 in the same cycle, with zero extra lag after an A0 write.

Read ports:
- Pure mux of the current register contents.
- All three ports may address the same register.

Widths:
- No arithmetic in the block; data is copied bit-exact.
- No sign or zero extension.

Test Plan:
- Reset: pulse rst low mid-cycle with A3 previously 24'h00ABCD -> A3 = 0, o_a0_zero = 1, all pulses 0 immediately (asynchronous), and held after release.
- Basic write-back: i_result_en = 1, src = 2, dest = 5, source 2 = 24'h123456 -> o_aj (j = 5) still shows the old value that cycle and 24'h123456 the next cycle. Back-to-back writes to dest 5 then dest 6 both land.
- A0 flags: write 24'h800000 to A0 -> next cycle o_a0_neg = 1, o_a0_zero = 0. Then write 0 -> o_a0_zero = 1, o_a0_neg = 0. Flags track o_a0 cycle-exactly.
- Illegal source: NSRC = 8, src = 4'd11, dest = 2, A2 = 24'h00FFFF -> A2 = 0 next cycle and a single-cycle o_src_err pulse. No pulse when i_result_en = 0 with src = 11.
- Maintenance conflict: i_mnt_we = 1, addr = 1, data = 24'h0000AA, together with result write dest = 4 -> A4 updated, A1 unchanged, o_mnt_conflict pulses once. A lone maintenance write the next cycle sets A1 = 24'h0000AA.
- Read ports: set A0..A7 = 24'h000010 + n, sweep i/j/k over all indices including i = j = k = 7 -> every port returns 24'h000017 in that case and the matching value for all others.
